// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared state enum, fixed-point defaults and weight table for the stream classifier
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } core_state_e;

  localparam int DATA_WIDTH        = 16;
  localparam int DATA_INT_WIDTH    = 8;
  localparam int DATA_FRAC_WIDTH   = 8;
  localparam int WEIGHT_WIDTH      = 16;
  localparam int WEIGHT_INT_WIDTH  = 8;
  localparam int WEIGHT_FRAC_WIDTH = 8;

  // Constant weight table: raw Q8.8 weights in -32..31 from a cheap hash of layer, neuron and input.
  function automatic int nn_weight(input int layer, input int neuron, input int idx);
    return (((neuron * 37) ^ (idx * 11) ^ (layer * 73)) & 63) - 32;
  endfunction

endpackage

// File: rtl/nn_frame_loader.sv
// rtl/nn_frame_loader.sv - ping/pong frame capture with pixLast framing checks
module nn_frame_loader
  import nn_pkg::*;
#(
  parameter int numInputs = 784,
  parameter int dataWidth = DATA_WIDTH,
  localparam int addrWidth = (numInputs > 1) ? $clog2(numInputs) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] pix_in,
  input  logic                 pix_valid,
  input  logic                 pix_last,
  output logic                 pix_ready,
  output logic                 frame_err,
  output logic [1:0]           full,
  input  logic                 rd_buf,
  input  logic [addrWidth-1:0] rd_addr,
  output logic [dataWidth-1:0] rd_data,
  output logic [7:0]           rd_frame_id,
  input  logic                 release_buf
);

  logic [addrWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic                 wr_buf_q, wr_buf_d;
  logic [1:0]           full_q, full_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [1:0][7:0]      fid_q, fid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 accept;
  logic [dataWidth-1:0] buf_mem [2][numInputs];

  assign pix_ready   = ~full_q[wr_buf_q];
  assign accept      = pix_valid & pix_ready;
  assign frame_err   = frame_err_q;
  assign full        = full_q;
  assign rd_data     = buf_mem[rd_buf][rd_addr];
  assign rd_frame_id = fid_q[rd_buf];

  // Frame bookkeeping: the core's release and a frame completion may land on different buffers in one cycle.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_buf_d    = wr_buf_q;
    full_d      = full_q;
    frame_cnt_d = frame_cnt_q;
    fid_d       = fid_q;
    frame_err_d = 1'b0;
    if (release_buf) full_d[rd_buf] = 1'b0;
    if (accept) begin
      if (wr_cnt_q == addrWidth'(numInputs - 1)) begin
        wr_cnt_d = '0;
        if (pix_last) begin
          full_d[wr_buf_q] = 1'b1;
          fid_d[wr_buf_q]  = frame_cnt_q;
          frame_cnt_d      = frame_cnt_q + 8'd1;
          wr_buf_d         = ~wr_buf_q;
        end else begin
          frame_err_d = 1'b1;
        end
      end else if (pix_last) begin
        wr_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + addrWidth'(1);
      end
    end
  end

  // Loader state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_buf_q    <= 1'b0;
      full_q      <= '0;
      frame_cnt_q <= '0;
      fid_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_buf_q    <= wr_buf_d;
      full_q      <= full_d;
      frame_cnt_q <= frame_cnt_d;
      fid_q       <= fid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Pixel storage; contents are meaningless until a full flag says otherwise, so no reset.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[wr_buf_q][wr_cnt_q] <= pix_in;
  end

endmodule

// File: rtl/nn_hardmax.sv
// rtl/nn_hardmax.sv - registered argmax over the output layer, lowest index wins ties
module nn_hardmax
  import nn_pkg::*;
#(
  parameter int numOutputs = 10,
  parameter int dataWidth  = DATA_WIDTH,
  localparam int idxWidth  = (numOutputs > 1) ? $clog2(numOutputs) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numOutputs*dataWidth-1:0] in_data,
  input  logic                            in_valid,
  output logic [idxWidth-1:0]             max_index,
  output logic [dataWidth-1:0]            max_value,
  output logic                            max_valid
);

  logic [idxWidth-1:0]         max_index_q, max_index_d, best_idx;
  logic [dataWidth-1:0]        max_value_q, max_value_d;
  logic                        max_valid_q, max_valid_d;
  logic signed [dataWidth-1:0] best_val;

  assign max_index = max_index_q;
  assign max_value = max_value_q;
  assign max_valid = max_valid_q;

  // Signed scan for the largest score; strict compare keeps the first maximum.
  always_comb begin
    best_idx = '0;
    best_val = in_data[dataWidth-1:0];
    for (int i = 1; i < numOutputs; i++) begin
      if ($signed(in_data[i*dataWidth +: dataWidth]) > best_val) begin
        best_val = in_data[i*dataWidth +: dataWidth];
        best_idx = idxWidth'(i);
      end
    end
    max_valid_d = in_valid;
    max_index_d = in_valid ? best_idx : max_index_q;
    max_value_d = in_valid ? best_val : max_value_q;
  end

  // Result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_index_q <= '0;
      max_value_q <= '0;
      max_valid_q <= 1'b0;
    end else begin
      max_index_q <= max_index_d;
      max_value_q <= max_value_d;
      max_valid_q <= max_valid_d;
    end
  end

endmodule

// File: rtl/nn_layer.sv
// rtl/nn_layer.sv - fully connected layer, one input per cycle into all neurons in parallel
module nn_layer
  import nn_pkg::*;
#(
  parameter int numIn       = 784,
  parameter int numNeurons  = 16,
  parameter int layerId     = 0,
  parameter bit doRelu      = 1'b1,
  parameter int dataWidth   = DATA_WIDTH,
  parameter int weightWidth = WEIGHT_WIDTH,
  parameter int fracShift   = WEIGHT_FRAC_WIDTH,
  localparam int addrWidth  = (numIn > 1) ? $clog2(numIn) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic [addrWidth-1:0]            rd_addr,
  input  logic [dataWidth-1:0]            rd_data,
  output logic [numNeurons*dataWidth-1:0] out_data,
  output logic                            out_valid
);

  localparam int accWidth = 48;
  localparam logic signed [accWidth-1:0] maxVal = (48'sd1 <<< (dataWidth - 1)) - 48'sd1;
  localparam logic signed [accWidth-1:0] minVal = -maxVal - 48'sd1;

  logic                            run_q, run_d;
  logic [addrWidth-1:0]            cnt_q, cnt_d;
  logic signed [accWidth-1:0]      acc_q [numNeurons];
  logic signed [accWidth-1:0]      acc_d [numNeurons];
  logic [numNeurons*dataWidth-1:0] out_q, out_d;
  logic                            out_valid_q, out_valid_d;
  logic signed [weightWidth-1:0]   w;
  logic signed [accWidth-1:0]      shifted;

  assign rd_addr   = cnt_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;

  // Multiply-accumulate, then rescale, optionally rectify and saturate once the last input is in.
  always_comb begin
    run_d       = run_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    w           = '0;
    shifted     = '0;
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      for (int n = 0; n < numNeurons; n++) acc_d[n] = '0;
    end else if (run_q) begin
      for (int n = 0; n < numNeurons; n++) begin
        w        = weightWidth'(nn_weight(layerId, n, int'(cnt_q)));
        acc_d[n] = acc_q[n] + accWidth'($signed(rd_data)) * accWidth'(w);
      end
      cnt_d = cnt_q + addrWidth'(1);
      if (cnt_q == addrWidth'(numIn - 1)) begin
        run_d       = 1'b0;
        out_valid_d = 1'b1;
        for (int n = 0; n < numNeurons; n++) begin
          shifted = acc_d[n] >>> fracShift;
          if (doRelu && shifted < 0) shifted = '0;
          if (shifted > maxVal) shifted = maxVal;
          else if (shifted < minVal) shifted = minVal;
          out_d[n*dataWidth +: dataWidth] = shifted[dataWidth-1:0];
        end
      end
    end
  end

  // Layer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q       <= 1'b0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int n = 0; n < numNeurons; n++) acc_q[n] <= '0;
    end else begin
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: rtl/nn_stream_top.sv
// rtl/nn_stream_top.sv - pixel stream to class result: loader, layer0 -> layer1 -> hardmax, result handshake
module nn_stream_top
  import nn_pkg::*;
#(
  parameter int numInputs       = 784,
  parameter int numOutputs      = 10,
  parameter int L0neurons       = 16,
  parameter int L1neurons       = 10,
  parameter int dataWidth       = DATA_WIDTH,
  parameter int dataIntWidth    = DATA_INT_WIDTH,
  parameter int dataFracWidth   = DATA_FRAC_WIDTH,
  parameter int weightWidth     = WEIGHT_WIDTH,
  parameter int weightIntWidth  = WEIGHT_INT_WIDTH,
  parameter int weightFracWidth = WEIGHT_FRAC_WIDTH,
  localparam int idxWidth       = (numOutputs > 1) ? $clog2(numOutputs) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [dataWidth-1:0] pixIn,
  input  logic                 pixValid,
  input  logic                 pixLast,
  output logic                 pixReady,
  output logic [idxWidth-1:0]  resIndex,
  output logic [dataWidth-1:0] resValue,
  output logic [7:0]           resFrameId,
  output logic                 resValid,
  input  logic                 resReady,
  output logic                 frameErr,
  output logic                 busy
);

  localparam int l0AddrWidth = (numInputs > 1) ? $clog2(numInputs) : 1;
  localparam int l1AddrWidth = (L0neurons > 1) ? $clog2(L0neurons) : 1;

  if (L1neurons != numOutputs || dataIntWidth + dataFracWidth != dataWidth ||
      weightIntWidth + weightFracWidth != weightWidth) begin : g_cfg_check
    $error("nn_stream_top: inconsistent layer or fixed-point parameters");
  end

  core_state_e                    state_q, state_d;
  logic                           rd_buf_q, rd_buf_d;
  logic [7:0]                     cur_fid_q, cur_fid_d;
  logic                           res_valid_q, res_valid_d;
  logic [idxWidth-1:0]            res_index_q, res_index_d;
  logic [dataWidth-1:0]           res_value_q, res_value_d;
  logic [7:0]                     res_frame_id_q, res_frame_id_d;
  logic                           layer_valid, release_buf;
  logic [1:0]                     full;
  logic [7:0]                     rd_frame_id;
  logic [l0AddrWidth-1:0]         l0_addr;
  logic [dataWidth-1:0]           l0_rd_data;
  logic [L0neurons*dataWidth-1:0] l0_out;
  logic                           l0_valid;
  logic [l1AddrWidth-1:0]         l1_addr;
  logic [L1neurons*dataWidth-1:0] l1_out;
  logic                           l1_valid;
  logic [idxWidth-1:0]            max_index;
  logic [dataWidth-1:0]           max_value;
  logic                           max_valid;

  nn_frame_loader #(.numInputs(numInputs), .dataWidth(dataWidth)) u_loader (
    .clk(clk), .rst(reset), .pix_in(pixIn), .pix_valid(pixValid), .pix_last(pixLast),
    .pix_ready(pixReady), .frame_err(frameErr), .full(full), .rd_buf(rd_buf_q),
    .rd_addr(l0_addr), .rd_data(l0_rd_data), .rd_frame_id(rd_frame_id), .release_buf(release_buf)
  );

  nn_layer #(.numIn(numInputs), .numNeurons(L0neurons), .layerId(0), .doRelu(1'b1),
             .dataWidth(dataWidth), .weightWidth(weightWidth), .fracShift(weightFracWidth)) u_layer0 (
    .clk(clk), .rst(reset), .start(layer_valid), .rd_addr(l0_addr), .rd_data(l0_rd_data),
    .out_data(l0_out), .out_valid(l0_valid)
  );

  nn_layer #(.numIn(L0neurons), .numNeurons(L1neurons), .layerId(1), .doRelu(1'b0),
             .dataWidth(dataWidth), .weightWidth(weightWidth), .fracShift(weightFracWidth)) u_layer1 (
    .clk(clk), .rst(reset), .start(l0_valid), .rd_addr(l1_addr),
    .rd_data(l0_out[l1_addr*dataWidth +: dataWidth]), .out_data(l1_out), .out_valid(l1_valid)
  );

  nn_hardmax #(.numOutputs(numOutputs), .dataWidth(dataWidth)) u_hardmax (
    .clk(clk), .rst(reset), .in_data(l1_out), .in_valid(l1_valid),
    .max_index(max_index), .max_value(max_value), .max_valid(max_valid)
  );

  assign resIndex   = res_index_q;
  assign resValue   = res_value_q;
  assign resFrameId = res_frame_id_q;
  assign resValid   = res_valid_q;
  assign busy       = (|full) | (state_q != ST_IDLE);

  // Core sequencing: launch on a full read buffer, capture the hardmax result, hold it until taken.
  always_comb begin
    state_d        = state_q;
    rd_buf_d       = rd_buf_q;
    cur_fid_d      = cur_fid_q;
    res_valid_d    = res_valid_q;
    res_index_d    = res_index_q;
    res_value_d    = res_value_q;
    res_frame_id_d = res_frame_id_q;
    layer_valid    = 1'b0;
    release_buf    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full[rd_buf_q]) begin
          layer_valid = 1'b1;
          cur_fid_d   = rd_frame_id;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (max_valid) begin
          res_index_d    = max_index;
          res_value_d    = max_value;
          res_frame_id_d = cur_fid_q;
          res_valid_d    = 1'b1;
          release_buf    = 1'b1;
          rd_buf_d       = ~rd_buf_q;
          state_d        = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_valid_q && resReady) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core FSM and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rd_buf_q       <= 1'b0;
      cur_fid_q      <= '0;
      res_valid_q    <= 1'b0;
      res_index_q    <= '0;
      res_value_q    <= '0;
      res_frame_id_q <= '0;
    end else begin
      state_q        <= state_d;
      rd_buf_q       <= rd_buf_d;
      cur_fid_q      <= cur_fid_d;
      res_valid_q    <= res_valid_d;
      res_index_q    <= res_index_d;
      res_value_q    <= res_value_d;
      res_frame_id_q <= res_frame_id_d;
    end
  end

endmodule

// File: tb/tb_nn_stream_top.sv
// tb/tb_nn_stream_top.sv - directed-sequence bench with random frames and a behavioural classifier model
module tb_nn_stream_top;
  import nn_pkg::*;

  localparam int N = 784;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pixIn;
  logic        pixValid, pixLast, pixReady;
  logic [3:0]  resIndex;
  logic [15:0] resValue;
  logic [7:0]  resFrameId;
  logic        resValid, resReady, frameErr, busy;

  always #5 clk = ~clk;

  nn_stream_top dut (
    .clk(clk), .reset(reset), .pixIn(pixIn), .pixValid(pixValid), .pixLast(pixLast),
    .pixReady(pixReady), .resIndex(resIndex), .resValue(resValue), .resFrameId(resFrameId),
    .resValid(resValid), .resReady(resReady), .frameErr(frameErr), .busy(busy)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] frames [4][N];
  int          exp_idx [4];
  logic [15:0] exp_val [4];

  int   lv_count = 0, err_count = 0, rv_rise = 0, ready_low = 0;
  logic rv_prev = 1'b0;

  // Event counters observed away from the active edge.
  always @(negedge clk) begin
    if (dut.layer_valid) lv_count++;
    if (frameErr) err_count++;
    if (resValid && !rv_prev) rv_rise++;
    if (pixValid && !pixReady) ready_low++;
    rv_prev = resValid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Classifier from first principles: Q8.8 dot products, floor rescale, ReLU, saturate, first argmax.
  function automatic void run_model(input int f, output int idx, output logic [15:0] val);
    longint h [16];
    longint acc, best;
    for (int n = 0; n < 16; n++) begin
      acc = 0;
      for (int i = 0; i < N; i++) acc += longint'(frames[f][i]) * longint'(nn_weight(0, n, i));
      acc = acc >>> 8;
      if (acc < 0) acc = 0;
      if (acc > 32767) acc = 32767;
      h[n] = acc;
    end
    best = 0;
    idx  = 0;
    for (int k = 0; k < 10; k++) begin
      acc = 0;
      for (int n = 0; n < 16; n++) acc += h[n] * longint'(nn_weight(1, k, n));
      acc = acc >>> 8;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      if (k == 0 || acc > best) begin
        best = acc;
        idx  = k;
      end
    end
    val = 16'(best);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pixValid = 1'b0;
    pixLast = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int f, input int nbeats, input int last_at);
    int guard;
    for (int b = 0; b < nbeats; b++) begin
      pixIn    = frames[f][b % N];
      pixValid = 1'b1;
      pixLast  = (b + 1 == last_at);
      guard    = 0;
      while (!pixReady && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      if (!pixReady) begin
        check("pix_ready_timeout", 32'(pixReady), 32'd1);
        pixValid = 1'b0;
        pixLast  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    pixValid = 1'b0;
    pixLast  = 1'b0;
  endtask

  task automatic wait_result(input int max_cycles, output bit got);
    int c;
    c = 0;
    while (!resValid && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    got = resValid;
    if (!got) check("result_timeout", 32'(resValid), 32'd1);
  endtask

  initial begin
    bit got;
    int base, base2, stable, guard;
    reset = 1'b1;
    pixIn = '0;
    pixValid = 1'b0;
    pixLast = 1'b0;
    resReady = 1'b0;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < N; i++) frames[f][i] = 16'($urandom_range(0, 255));
    for (int f = 0; f < 4; f++) run_model(f, exp_idx[f], exp_val[f]);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_pix_ready", 32'(pixReady), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(resValid), 32'd0);
    check("rst_frame_err", 32'(frameErr), 32'd0);
    check("rst_res_index", 32'(resIndex), 32'd0);
    check("rst_res_value", 32'(resValue), 32'd0);
    check("rst_res_frame_id", 32'(resFrameId), 32'd0);

    base = lv_count;
    send_frame(0, N, N);
    wait_result(2000, got);
    if (got) begin
      check("one_frame_id", 32'(resFrameId), 32'd0);
      check("one_frame_index", 32'(resIndex), 32'(exp_idx[0]));
      check("one_frame_value", 32'(resValue), 32'(exp_val[0]));
    end
    check("one_frame_layer_valid_pulses", 32'(lv_count - base), 32'd1);

    stable = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (resValid === 1'b1 && resIndex === 4'(exp_idx[0]) && resValue === exp_val[0] &&
          dut.state_q === ST_RESULT) stable++;
    end
    check("hold_stable_cycles", 32'(stable), 32'd50);
    check("hold_state_result", 32'(dut.state_q), 32'(ST_RESULT));
    resReady = 1'b1;
    @(negedge clk);
    check("release_res_valid", 32'(resValid), 32'd0);
    check("release_busy", 32'(busy), 32'd0);

    do_reset();
    base = err_count;
    base2 = rv_rise;
    send_frame(1, 100, 100);
    repeat (3) @(negedge clk);
    check("early_frame_err_pulses", 32'(err_count - base), 32'd1);
    repeat (900) @(negedge clk);
    check("early_no_result", 32'(rv_rise - base2), 32'd0);
    check("early_busy", 32'(busy), 32'd0);
    send_frame(1, N, N);
    wait_result(2000, got);
    if (got) begin
      check("early_next_id", 32'(resFrameId), 32'd0);
      check("early_next_index", 32'(resIndex), 32'(exp_idx[1]));
      check("early_next_value", 32'(resValue), 32'(exp_val[1]));
    end
    @(negedge clk);

    base = err_count;
    send_frame(2, N, 0);
    repeat (2) @(negedge clk);
    check("late_frame_err_pulses", 32'(err_count - base), 32'd1);
    check("late_wr_cnt", 32'(dut.u_loader.wr_cnt_q), 32'd0);
    check("late_busy", 32'(busy), 32'd0);

    do_reset();
    resReady = 1'b1;
    base = ready_low;
    fork
      begin
        send_frame(0, N, N);
        send_frame(1, N, N);
        send_frame(2, N, N);
      end
      begin
        for (int r = 0; r < 3; r++) begin
          wait_result(5000, got);
          if (got) begin
            check($sformatf("b2b_id_%0d", r), 32'(resFrameId), 32'(r));
            check($sformatf("b2b_index_%0d", r), 32'(resIndex), 32'(exp_idx[r]));
            check($sformatf("b2b_value_%0d", r), 32'(resValue), 32'(exp_val[r]));
          end
          @(negedge clk);
        end
      end
    join
    check("b2b_pix_ready_dropped", 32'(ready_low > base), 32'd1);

    send_frame(3, N, N);
    guard = 0;
    while (dut.state_q !== ST_RUN && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (200) @(negedge clk);
    check("midrun_state_run", 32'(dut.state_q), 32'(ST_RUN));
    base = rv_rise;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrun_pix_ready_after_reset", 32'(pixReady), 32'd1);
    check("midrun_busy_after_reset", 32'(busy), 32'd0);
    repeat (1000) @(negedge clk);
    check("midrun_no_result", 32'(rv_rise - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the end, %0d checks so far", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
